// File: rtl/soc_fpga_code_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : soc_fpga_code_loader_if
// Brief    : Byte-stream input and code RAM write port of the code loader.
// Revision : 1.0 - initial release
// ============================================================================
interface soc_fpga_code_loader_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 12
);
  logic [7:0]           RxData;
  logic                 RxValid;
  logic                 RxReady;
  logic [ADDRWIDTH-1:0] MemAddr;
  logic [DATAWIDTH-1:0] MemDataOut;
  logic                 MemWriteEnable;

  // Byte source / RAM sink side
  modport master (
    output RxData, RxValid,
    input  RxReady, MemAddr, MemDataOut, MemWriteEnable
  );

  // Loader side
  modport slave (
    input  RxData, RxValid,
    output RxReady, MemAddr, MemDataOut, MemWriteEnable
  );
endinterface
`default_nettype wire

// File: rtl/soc_fpga_code_loader.sv
`default_nettype none
// ============================================================================
// Module   : soc_fpga_code_loader
// Brief    : Framed byte-stream boot loader writing little-endian words into
//            code RAM; optional inter-byte timeout via CODE_LOADER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module soc_fpga_code_loader #(
  parameter int          DATAWIDTH      = 32,
  parameter int          ADDRWIDTH      = 12,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  wire logic             PortAClk,
  input  wire logic             PortAReset,
  input  wire logic             LoadStart,
  soc_fpga_code_loader_if.slave bus,
  output logic                  LoadDone,
  output logic                  LoadError,
  output logic [1:0]            ErrCode,
  output logic                  CpuHold
);
  localparam int          BPW      = DATAWIDTH / 8;
  localparam int          BIDXW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [31:0] MEMDEPTH = 32'd1 << ADDRWIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [1:0]           w_nextErr;
  logic [7:0]           r_lenHi;
  logic [15:0]          r_wordCount;
  logic [31:0]          r_wordIdx;
  logic [BIDXW-1:0]     r_byteIdx;
  logic [7:0]           r_csum;
  logic [DATAWIDTH-1:0] r_wordBuf;
  logic [DATAWIDTH-1:0] w_wordNext;
  logic                 w_accept;
  logic                 w_lastByte;
  logic                 w_lastWord;
  logic [15:0]          w_len;
  logic [7:0]           w_sum;
  logic                 w_timeout;

  assign w_accept   = bus.RxValid && bus.RxReady;
  assign w_len      = {r_lenHi, bus.RxData};
  assign w_sum      = r_csum + bus.RxData;
  assign w_lastByte = (r_byteIdx == BIDXW'(BPW - 1));
  assign w_lastWord = ((r_wordIdx + 32'd1) == {16'd0, r_wordCount});

`ifdef CODE_LOADER_TIMEOUT_EN
  logic [31:0] r_timeoutCnt;
  logic        w_active;

  assign w_active  = (r_state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM});
  assign w_timeout = w_active && !w_accept &&
                     (r_timeoutCnt == 32'(TIMEOUT_CYCLES - 1));

  // State entries inside the active set always coincide with a handshake,
  // so clearing on accept also covers clearing on entry.
  always_ff @(posedge PortAClk) begin
    if (PortAReset || !w_active || w_accept) begin
      r_timeoutCnt <= '0;
    end else begin
      r_timeoutCnt <= r_timeoutCnt + 32'd1;
    end
  end
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout       = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    w_nextErr   = ErrCode;
    w_wordNext  = r_wordBuf;
    for (int k = 0; k < BPW; k++) begin
      if (r_byteIdx == BIDXW'(k)) begin
        w_wordNext[8*k +: 8] = bus.RxData;
      end
    end
    case (r_state)
      S_IDLE:   if (w_accept && (bus.RxData == SYNC_BYTE)) w_nextState = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_nextState = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if ({16'd0, w_len} > MEMDEPTH) begin
            w_nextState = S_ERROR;
            w_nextErr   = 2'd1;
          end else if (w_len == 16'd0) begin
            w_nextState = S_CSUM;
          end else begin
            w_nextState = S_DATA;
          end
        end
      end
      S_DATA:   if (w_accept && w_lastByte && w_lastWord) w_nextState = S_CSUM;
      S_CSUM: begin
        if (w_accept) begin
          if (w_sum == 8'd0) begin
            w_nextState = S_DONE;
          end else begin
            w_nextState = S_ERROR;
            w_nextErr   = 2'd2;
          end
        end
      end
      S_DONE:   if (LoadStart) w_nextState = S_IDLE;
      S_ERROR: begin
        if (LoadStart) begin
          w_nextState = S_IDLE;
          w_nextErr   = 2'd0;
        end
      end
      default:  w_nextState = S_IDLE;
    endcase
    if (w_timeout) begin
      w_nextState = S_ERROR;
      w_nextErr   = 2'd3;
    end
  end

  always_ff @(posedge PortAClk) begin
    if (PortAReset) begin
      r_state            <= S_IDLE;
      r_lenHi            <= '0;
      r_wordCount        <= '0;
      r_wordIdx          <= '0;
      r_byteIdx          <= '0;
      r_csum             <= '0;
      r_wordBuf          <= '0;
      bus.RxReady        <= 1'b1;
      bus.MemAddr        <= '0;
      bus.MemDataOut     <= '0;
      bus.MemWriteEnable <= 1'b0;
      LoadDone           <= 1'b0;
      LoadError          <= 1'b0;
      ErrCode            <= 2'd0;
      CpuHold            <= 1'b1;
    end else begin
      r_state            <= w_nextState;
      bus.RxReady        <= (w_nextState != S_DONE) && (w_nextState != S_ERROR);
      LoadDone           <= (w_nextState == S_DONE);
      LoadError          <= (w_nextState == S_ERROR);
      CpuHold            <= (w_nextState != S_DONE);
      ErrCode            <= w_nextErr;
      bus.MemWriteEnable <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (bus.RxData == SYNC_BYTE) begin
              r_csum      <= '0;
              r_byteIdx   <= '0;
              r_wordIdx   <= '0;
              r_wordBuf   <= '0;
              bus.MemAddr <= '0;
            end
          end
          S_LEN_HI: begin
            r_lenHi <= bus.RxData;
            r_csum  <= w_sum;
          end
          S_LEN_LO: begin
            r_wordCount <= w_len;
            r_csum      <= w_sum;
          end
          S_DATA: begin
            r_csum <= w_sum;
            if (w_lastByte) begin
              r_byteIdx          <= '0;
              r_wordBuf          <= '0;
              r_wordIdx          <= r_wordIdx + 32'd1;
              bus.MemWriteEnable <= 1'b1;
              bus.MemDataOut     <= w_wordNext;
              bus.MemAddr        <= r_wordIdx[ADDRWIDTH-1:0];
            end else begin
              r_byteIdx <= r_byteIdx + BIDXW'(1);
              r_wordBuf <= w_wordNext;
            end
          end
          S_CSUM:  r_csum <= w_sum;
          default: ;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_soc_fpga_code_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_fpga_code_loader
// Brief    : Self-checking bench for soc_fpga_code_loader (32-bit words, 16-deep RAM).
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_fpga_code_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loadStart = 1'b0;
  logic loadDone, loadError, cpuHold;
  logic [1:0] errCode;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrData [$];
  logic [3:0]  wrAddr [$];

  soc_fpga_code_loader_if #(.DATAWIDTH(32), .ADDRWIDTH(4)) bus ();

  soc_fpga_code_loader #(
    .DATAWIDTH(32), .ADDRWIDTH(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
  ) dut (
    .PortAClk(clk), .PortAReset(rst), .LoadStart(loadStart), .bus(bus),
    .LoadDone(loadDone), .LoadError(loadError), .ErrCode(errCode), .CpuHold(cpuHold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.MemWriteEnable) begin
      wrData.push_back(bus.MemDataOut);
      wrAddr.push_back(bus.MemAddr);
    end
  end

  typedef struct {
    logic [127:0] stream;
    int           nBytes;
    int           expWrites;
    logic [31:0]  expWord [2];
    logic         expDone;
    logic         expErr;
    logic [1:0]   expCode;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    bus.RxData  = b;
    bus.RxValid = 1'b1;
    while (!bus.RxReady && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      errors++;
      $display("FAIL send_timeout actual=RxReady_low expected=RxReady_high byte=%0h", b);
    end
    tick();
  endtask

  task automatic idle(input int n);
    bus.RxValid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulseStart();
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_rxready"}, 64'(bus.RxReady), 64'd1);
    check({tag, "_done"},    64'(loadDone),    64'd0);
    check({tag, "_error"},   64'(loadError),   64'd0);
    check({tag, "_errcode"}, 64'(errCode),     64'd0);
    check({tag, "_cpuhold"}, 64'(cpuHold),     64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bus.RxData  = 8'h00;
    bus.RxValid = 1'b0;

    vecs[0] = '{stream: 128'hA5_00_02_11_22_33_44_55_66_77_88_9A, nBytes: 12, expWrites: 2,
                expWord: '{32'h44332211, 32'h88776655}, expDone: 1'b1, expErr: 1'b0, expCode: 2'd0};
    vecs[1] = '{stream: 128'hA5_00_02_11_22_33_44_55_66_77_88_9B, nBytes: 12, expWrites: 2,
                expWord: '{32'h44332211, 32'h88776655}, expDone: 1'b0, expErr: 1'b1, expCode: 2'd2};
    vecs[2] = '{stream: 128'hA5_00_11, nBytes: 3, expWrites: 0,
                expWord: '{32'h0, 32'h0}, expDone: 1'b0, expErr: 1'b1, expCode: 2'd1};
    vecs[3] = '{stream: 128'h00_FF_A5_00_00_00, nBytes: 6, expWrites: 0,
                expWord: '{32'h0, 32'h0}, expDone: 1'b1, expErr: 1'b0, expCode: 2'd0};
    vecs[4] = '{stream: 128'hA5_00_01_A5_01_02_03_54, nBytes: 8, expWrites: 1,
                expWord: '{32'h030201A5, 32'h0}, expDone: 1'b1, expErr: 1'b0, expCode: 2'd0};

    tick(); tick();
    check("rst_rxready", 64'(bus.RxReady),        64'd1);
    check("rst_memaddr", 64'(bus.MemAddr),        64'd0);
    check("rst_memdata", 64'(bus.MemDataOut),     64'd0);
    check("rst_memwe",   64'(bus.MemWriteEnable), 64'd0);
    check("rst_done",    64'(loadDone),           64'd0);
    check("rst_error",   64'(loadError),          64'd0);
    check("rst_errcode", 64'(errCode),            64'd0);
    check("rst_cpuhold", 64'(cpuHold),            64'd1);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      wrData.delete();
      wrAddr.delete();
      for (int j = 0; j < vecs[v].nBytes; j++) begin
        b = vecs[v].stream[8*(vecs[v].nBytes-1-j) +: 8];
        sendByte(b);
      end
      idle(2);
      check($sformatf("v%0d_done", v),    64'(loadDone),      64'(vecs[v].expDone));
      check($sformatf("v%0d_error", v),   64'(loadError),     64'(vecs[v].expErr));
      check($sformatf("v%0d_errcode", v), 64'(errCode),       64'(vecs[v].expCode));
      check($sformatf("v%0d_cpuhold", v), 64'(cpuHold),       64'(!vecs[v].expDone));
      check($sformatf("v%0d_rxready", v), 64'(bus.RxReady),   64'd0);
      check($sformatf("v%0d_nwrites", v), 64'(wrData.size()), 64'(vecs[v].expWrites));
      for (int j = 0; j < vecs[v].expWrites; j++) begin
        if (j < wrData.size()) begin
          check($sformatf("v%0d_addr%0d", v, j), 64'(wrAddr[j]), 64'(j));
          check($sformatf("v%0d_data%0d", v, j), 64'(wrData[j]), 64'(vecs[v].expWord[j]));
        end
      end
      pulseStart();
      checkIdle($sformatf("v%0d_restart", v));
    end

    // Full-depth image: N == MEMDEPTH, data byte j has value j
    wrData.delete();
    wrAddr.delete();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h10);
    for (int j = 0; j < 64; j++) sendByte(8'(j));
    sendByte(8'h10);
    idle(2);
    check("full_done",    64'(loadDone),      64'd1);
    check("full_nwrites", 64'(wrData.size()), 64'd16);
    for (int w = 0; w < 16; w++) begin
      if (w < wrData.size()) begin
        check($sformatf("full_addr%0d", w), 64'(wrAddr[w]), 64'(w));
        check($sformatf("full_data%0d", w), 64'(wrData[w]), 64'(32'h03020100 + 32'(w) * 32'h04040404));
      end
    end
    pulseStart();
    checkIdle("full_restart");

    // Reset after the 5th data byte, then a clean frame
    wrData.delete();
    wrAddr.delete();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44); sendByte(8'h55);
    bus.RxValid = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_memdata", 64'(bus.MemDataOut),     64'd0);
    check("mid_rst_memwe",   64'(bus.MemWriteEnable), 64'd0);
    check("mid_rst_memaddr", 64'(bus.MemAddr),        64'd0);
    checkIdle("mid_rst");
    rst = 1'b0;
    tick();
    wrData.delete();
    wrAddr.delete();
    for (int j = 0; j < vecs[0].nBytes; j++) begin
      b = vecs[0].stream[8*(vecs[0].nBytes-1-j) +: 8];
      sendByte(b);
    end
    idle(2);
    check("post_rst_done",    64'(loadDone),      64'd1);
    check("post_rst_nwrites", 64'(wrData.size()), 64'd2);
    if (wrData.size() == 2) begin
      check("post_rst_data1", 64'(wrData[1]), 64'h88776655);
    end
    pulseStart();

    // Stall inside DATA with a stray LoadStart, then finish the frame
    wrData.delete();
    wrAddr.delete();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01); sendByte(8'h11);
    idle(10);
    pulseStart();
    idle(10);
`ifdef CODE_LOADER_TIMEOUT_EN
    check("stall_error",   64'(loadError), 64'd1);
    check("stall_errcode", 64'(errCode),   64'd3);
    pulseStart();
`else
    check("stall_error",   64'(loadError),   64'd0);
    check("stall_rxready", 64'(bus.RxReady), 64'd1);
    sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    check("latency_we",    64'(bus.MemWriteEnable), 64'd1);
    check("latency_data",  64'(bus.MemDataOut),     64'h44332211);
    sendByte(8'h55);
    check("latency_we_off", 64'(bus.MemWriteEnable), 64'd0);
    check("stall_done",    64'(loadDone),    64'd1);
    check("stall_nwrites", 64'(wrData.size()), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
